// File: rtl/partition_sched_pkg.sv
// Shared types and elaboration-time helpers for the partition scheduler.
package partition_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_TILE,
    ST_DONE
  } sched_state_e;

  function automatic int tiles_x(input int array_width, input int part_width, input int stride);
    return (array_width - part_width) / stride + 1;
  endfunction

  function automatic int tiles_y(input int array_height, input int part_height, input int stride);
    return (array_height - part_height) / stride + 1;
  endfunction

  function automatic int row_step(input int stride, input int array_width);
    return stride * array_width;
  endfunction

endpackage

// File: rtl/tile_index_counter.sv
// Nested tx/ty raster counter tracking the base address of the current partition.
module tile_index_counter #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int TILES_X       = 1,
  parameter int TILES_Y       = 1,
  parameter int COL_STEP      = 1,
  parameter int ROW_STEP      = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     advance_i,
  input  logic [ADDRESS_WIDTH-1:0] base_i,
  output logic [ADDRESS_WIDTH-1:0] tx_o,
  output logic [ADDRESS_WIDTH-1:0] ty_o,
  output logic [ADDRESS_WIDTH-1:0] cur_base_o,
  output logic                     last_o
);

  localparam logic [ADDRESS_WIDTH-1:0] TX_LAST = ADDRESS_WIDTH'(TILES_X - 1);
  localparam logic [ADDRESS_WIDTH-1:0] TY_LAST = ADDRESS_WIDTH'(TILES_Y - 1);
  localparam logic [ADDRESS_WIDTH-1:0] COL_INC = ADDRESS_WIDTH'(COL_STEP);
  localparam logic [ADDRESS_WIDTH-1:0] ROW_INC = ADDRESS_WIDTH'(ROW_STEP);

  logic [ADDRESS_WIDTH-1:0] tx_q, tx_d;
  logic [ADDRESS_WIDTH-1:0] ty_q, ty_d;
  logic [ADDRESS_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDRESS_WIDTH-1:0] cur_base_q, cur_base_d;

  assign last_o = (tx_q == TX_LAST) && (ty_q == TY_LAST);

  always_comb begin
    tx_d       = tx_q;
    ty_d       = ty_q;
    row_base_d = row_base_q;
    cur_base_d = cur_base_q;
    if (clear_i) begin
      tx_d       = '0;
      ty_d       = '0;
      row_base_d = base_i;
      cur_base_d = base_i;
    end else if (advance_i && !last_o) begin
      if (tx_q != TX_LAST) begin
        tx_d       = tx_q + 1'b1;
        cur_base_d = cur_base_q + COL_INC;
      end else begin
        // Wrap to the next row: the new partition base is the advanced row base.
        tx_d       = '0;
        ty_d       = ty_q + 1'b1;
        row_base_d = row_base_q + ROW_INC;
        cur_base_d = row_base_q + ROW_INC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q       <= '0;
      ty_q       <= '0;
      row_base_q <= '0;
      cur_base_q <= '0;
    end else begin
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      row_base_q <= row_base_d;
      cur_base_q <= cur_base_d;
    end
  end

  assign tx_o       = tx_q;
  assign ty_o       = ty_q;
  assign cur_base_o = cur_base_q;

endmodule

// File: rtl/partition_scheduler.sv
// Walks the address generator over every partition of a feature map and emits a token per partition.
// state | meaning
// IDLE  | waiting for start
// LOAD  | generator latches agen_address (agen_run low)
// RUN   | generator walks the window until agen_done
// TILE  | token offered on tile_valid until tile_ready
// DONE  | one-cycle done pulse, then back to IDLE
module partition_scheduler
  import partition_sched_pkg::*;
#(
  parameter int ARRAY_WIDTH      = 28,
  parameter int ARRAY_HEIGHT     = 28,
  parameter int PARTITION_WIDTH  = 5,
  parameter int PARTITION_HEIGHT = 5,
  parameter int STRIDE           = 1,
  parameter int ADDRESS_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  output logic [ADDRESS_WIDTH-1:0] agen_address,
  output logic                     agen_run,
  input  logic                     agen_done,
  output logic                     tile_valid,
  input  logic                     tile_ready,
  output logic [ADDRESS_WIDTH-1:0] tile_x,
  output logic [ADDRESS_WIDTH-1:0] tile_y,
  output logic                     busy,
  output logic                     done
);

  localparam int TILES_X = tiles_x(ARRAY_WIDTH, PARTITION_WIDTH, STRIDE);
  localparam int TILES_Y = tiles_y(ARRAY_HEIGHT, PARTITION_HEIGHT, STRIDE);
  localparam int ROW_STP = row_step(STRIDE, ARRAY_WIDTH);

  sched_state_e state_q, state_d;
  logic         clear;
  logic         advance;
  logic         last;

  assign clear   = (state_q == ST_IDLE) && start;
  assign advance = (state_q == ST_TILE) && tile_ready;

  tile_index_counter #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .TILES_X       (TILES_X),
    .TILES_Y       (TILES_Y),
    .COL_STEP      (STRIDE),
    .ROW_STEP      (ROW_STP)
  ) u_index (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear),
    .advance_i  (advance),
    .base_i     (base_addr),
    .tx_o       (tile_x),
    .ty_o       (tile_y),
    .cur_base_o (agen_address),
    .last_o     (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)      state_d = ST_LOAD;
      ST_LOAD:                 state_d = ST_RUN;
      ST_RUN:  if (agen_done)  state_d = ST_TILE;
      ST_TILE: if (tile_ready) state_d = last ? ST_DONE : ST_LOAD;
      ST_DONE:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Outputs decode the state register only, so reset clears them without a clock.
  assign agen_run   = (state_q == ST_RUN);
  assign tile_valid = (state_q == ST_TILE);
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_TILE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_partition_scheduler.sv
// Four scheduler configurations against a tile-index-level reference model and generator stand-in.
module tb_partition_scheduler;

  localparam int NI = 4;
  // instance: 0 = 6x6/3x3/s1, 1 = 3x3/2x2/s1 (wrap), 2 = 6x6/3x3/s3, 3 = 4x4/4x4/s1
  localparam int CW  [NI] = '{6, 3, 6, 4};
  localparam int CPW [NI] = '{3, 2, 3, 4};
  localparam int CS  [NI] = '{1, 1, 3, 1};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NI-1:0] start, agen_run, agen_done, tile_valid, tile_ready, busy, done, noise;
  logic [15:0]   base_addr [NI];
  logic [15:0]   agen_address [NI];
  logic [15:0]   tile_x [NI];
  logic [15:0]   tile_y [NI];

  partition_scheduler #(.ARRAY_WIDTH(6), .ARRAY_HEIGHT(6), .PARTITION_WIDTH(3), .PARTITION_HEIGHT(3),
                        .STRIDE(1), .ADDRESS_WIDTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .base_addr(base_addr[0]), .agen_address(agen_address[0]),
    .agen_run(agen_run[0]), .agen_done(agen_done[0]), .tile_valid(tile_valid[0]), .tile_ready(tile_ready[0]),
    .tile_x(tile_x[0]), .tile_y(tile_y[0]), .busy(busy[0]), .done(done[0]));
  partition_scheduler #(.ARRAY_WIDTH(3), .ARRAY_HEIGHT(3), .PARTITION_WIDTH(2), .PARTITION_HEIGHT(2),
                        .STRIDE(1), .ADDRESS_WIDTH(16)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .base_addr(base_addr[1]), .agen_address(agen_address[1]),
    .agen_run(agen_run[1]), .agen_done(agen_done[1]), .tile_valid(tile_valid[1]), .tile_ready(tile_ready[1]),
    .tile_x(tile_x[1]), .tile_y(tile_y[1]), .busy(busy[1]), .done(done[1]));
  partition_scheduler #(.ARRAY_WIDTH(6), .ARRAY_HEIGHT(6), .PARTITION_WIDTH(3), .PARTITION_HEIGHT(3),
                        .STRIDE(3), .ADDRESS_WIDTH(16)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .base_addr(base_addr[2]), .agen_address(agen_address[2]),
    .agen_run(agen_run[2]), .agen_done(agen_done[2]), .tile_valid(tile_valid[2]), .tile_ready(tile_ready[2]),
    .tile_x(tile_x[2]), .tile_y(tile_y[2]), .busy(busy[2]), .done(done[2]));
  partition_scheduler #(.ARRAY_WIDTH(4), .ARRAY_HEIGHT(4), .PARTITION_WIDTH(4), .PARTITION_HEIGHT(4),
                        .STRIDE(1), .ADDRESS_WIDTH(16)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .base_addr(base_addr[3]), .agen_address(agen_address[3]),
    .agen_run(agen_run[3]), .agen_done(agen_done[3]), .tile_valid(tile_valid[3]), .tile_ready(tile_ready[3]),
    .tile_x(tile_x[3]), .tile_y(tile_y[3]), .busy(busy[3]), .done(done[3]));

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(input string name, input int k, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endfunction

  function automatic int tiles(input int k);
    return (CW[k] - CPW[k]) / CS[k] + 1;
  endfunction

  // Generator stand-in: done on the last window element, random noise when not running.
  int gcnt [NI];
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n)           gcnt[k] <= 0;
      else if (agen_run[k]) gcnt[k] <= gcnt[k] + 1;
      else                  gcnt[k] <= 0;
    end
  end
  always_comb begin
    agen_done = '0;
    for (int k = 0; k < NI; k++)
      agen_done[k] = agen_run[k] ? (gcnt[k] == CPW[k] * CPW[k] - 1) : noise[k];
  end

  // Reference model: phase 0 idle, 1 load, 2 run, 3 token, 4 done; tile number t in raster order.
  int          m_ph [NI];
  int          m_rc [NI];
  int          m_t  [NI];
  logic [15:0] m_base [NI];
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_ph[k] <= 0; m_rc[k] <= 0; m_t[k] <= 0; m_base[k] <= '0;
      end else begin
        case (m_ph[k])
          0: if (start[k]) begin m_ph[k] <= 1; m_t[k] <= 0; m_base[k] <= base_addr[k]; end
          1: begin m_ph[k] <= 2; m_rc[k] <= 0; end
          2: if (m_rc[k] == CPW[k] * CPW[k] - 1) m_ph[k] <= 3; else m_rc[k] <= m_rc[k] + 1;
          3: if (tile_ready[k]) begin
               if (m_t[k] == tiles(k) * tiles(k) - 1) m_ph[k] <= 4;
               else begin m_t[k] <= m_t[k] + 1; m_ph[k] <= 1; end
             end
          default: m_ph[k] <= 0;
        endcase
      end
    end
  end

  function automatic int exp_addr(input int k);
    int tx, ty, a;
    tx = m_t[k] % tiles(k);
    ty = m_t[k] / tiles(k);
    a  = int'(m_base[k]) + ty * CS[k] * CW[k] + tx * CS[k];
    return a & 32'h0000_FFFF;
  endfunction

  int toks [NI];
  int dones [NI];
  int runs [NI];
  int bsy [NI];
  int ldn [NI];
  int ldv [NI][16];
  int nstall;
  int stall;
  int rmode [NI];

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NI; k++) begin
        chk("agen_run", k, int'(agen_run[k]), int'(m_ph[k] == 2));
        chk("busy", k, int'(busy[k]), int'(m_ph[k] >= 1 && m_ph[k] <= 3));
        chk("done", k, int'(done[k]), int'(m_ph[k] == 4));
        chk("tile_valid", k, int'(tile_valid[k]), int'(m_ph[k] == 3));
        if (m_ph[k] == 1) begin
          chk("agen_address", k, int'(agen_address[k]), exp_addr(k));
          if (ldn[k] < 16) ldv[k][ldn[k]] = int'(agen_address[k]);
          ldn[k]++;
        end
        if (m_ph[k] == 3) begin
          chk("tile_x", k, int'(tile_x[k]), m_t[k] % tiles(k));
          chk("tile_y", k, int'(tile_y[k]), m_t[k] / tiles(k));
        end
        if (tile_valid[k] && tile_ready[k]) toks[k]++;
        if (done[k]) dones[k]++;
        if (agen_run[k]) runs[k]++;
        if (busy[k]) bsy[k]++;
      end
      if (rmode[0] == 2 && tile_valid[0] && !tile_ready[0]) begin
        nstall++;
        chk("stall_tile_x", 0, int'(tile_x[0]), 2);
        chk("stall_tile_y", 0, int'(tile_y[0]), 1);
        chk("stall_agen_run", 0, int'(agen_run[0]), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    noise = 4'($urandom);
    for (int k = 0; k < NI; k++) begin
      case (rmode[k])
        0: tile_ready[k] = 1'b1;
        1: tile_ready[k] = 1'($urandom);
        default: begin
          if (tile_valid[k] && tile_x[k] == 16'd2 && tile_y[k] == 16'd1 && stall < 5) begin
            tile_ready[k] = 1'b0;
            stall++;
          end else tile_ready[k] = 1'b1;
        end
      endcase
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < NI; k++) begin
      toks[k] = 0; dones[k] = 0; runs[k] = 0; bsy[k] = 0; ldn[k] = 0;
    end
    nstall = 0;
    stall  = 0;
  endtask

  task automatic start_run(input logic [NI-1:0] mask);
    step();
    start = mask;
    step();
    start = '0;
  endtask

  task automatic wait_done(input logic [NI-1:0] mask, input int poke);
    int i;
    for (i = 0; i < 4000 && ((done_seen() & mask) != mask); i++) begin
      step();
      if (i == poke) start[0] = 1'b1;
      if (i == poke + 1) start[0] = 1'b0;
    end
    if (i >= 4000) chk("wait_done_timeout", 0, i, 0);
    step();
  endtask

  function automatic logic [NI-1:0] done_seen();
    logic [NI-1:0] r;
    for (int k = 0; k < NI; k++) r[k] = (dones[k] != 0);
    return r;
  endfunction

  localparam int EXP_A [16] = '{100, 101, 102, 103, 106, 107, 108, 109,
                                112, 113, 114, 115, 118, 119, 120, 121};
  localparam int EXP_B [4]  = '{32'hFFFE, 32'hFFFF, 1, 2};
  localparam int EXP_C [4]  = '{0, 3, 18, 21};

  initial begin
    int i;
    rst_n = 1'b0;
    start = '0;
    noise = '0;
    tile_ready = '0;
    for (int k = 0; k < NI; k++) begin base_addr[k] = '0; rmode[k] = 0; end
    clear_stats();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_agen_address", k, int'(agen_address[k]), 0);
      chk("rst_busy", k, int'(busy[k]), 0);
      chk("rst_tile_valid", k, int'(tile_valid[k]), 0);
      chk("rst_done", k, int'(done[k]), 0);
    end

    // Directed maps with ready tied high; a stray start hits instance 0 mid-run.
    base_addr[0] = 16'd100;
    base_addr[1] = 16'hFFFE;
    base_addr[2] = 16'd0;
    base_addr[3] = 16'($urandom);
    clear_stats();
    start_run(4'hF);
    wait_done(4'hF, 30);
    chk("tokens", 0, toks[0], 16);
    chk("tokens", 1, toks[1], 4);
    chk("tokens", 2, toks[2], 4);
    chk("tokens", 3, toks[3], 1);
    for (int k = 0; k < NI; k++) chk("done_pulses", k, dones[k], 1);
    chk("run_cycles", 0, runs[0], 144);
    chk("run_cycles", 3, runs[3], 16);
    chk("busy_cycles", 0, bsy[0], 176);
    chk("loads", 3, ldn[3], 1);
    for (int j = 0; j < 16; j++) chk("load_addr_list", 0, ldv[0][j], EXP_A[j]);
    for (int j = 0; j < 4; j++) chk("load_addr_list", 1, ldv[1][j], EXP_B[j]);
    for (int j = 0; j < 4; j++) chk("load_addr_list", 2, ldv[2][j], EXP_C[j]);

    // Back-pressure: instance 0 stalls five cycles on (2,1), the rest see random ready.
    rmode[0] = 2;
    for (int k = 1; k < NI; k++) begin rmode[k] = 1; base_addr[k] = 16'($urandom); end
    base_addr[0] = 16'($urandom);
    clear_stats();
    start_run(4'hF);
    wait_done(4'hF, -10);
    chk("stall_cycles", 0, nstall, 5);
    chk("tokens_stall", 0, toks[0], 16);
    chk("tokens_rand", 1, toks[1], 4);

    // Random ready with reset asserted during the run of tile 5.
    rmode[0] = 1;
    base_addr[0] = 16'($urandom);
    clear_stats();
    start_run(4'h1);
    for (i = 0; i < 3000 && !(m_ph[0] == 2 && m_t[0] == 5 && m_rc[0] == 3); i++) step();
    if (i >= 3000) chk("reach_tile5_timeout", 0, i, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_agen_run", 0, int'(agen_run[0]), 0);
    chk("async_busy", 0, int'(busy[0]), 0);
    chk("async_done", 0, int'(done[0]), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) step();
    chk("no_done_after_reset", 0, dones[0], 0);

    // Fresh start restarts from tile (0,0).
    rmode[0] = 0;
    base_addr[0] = 16'd200;
    clear_stats();
    start_run(4'h1);
    wait_done(4'h1, -10);
    chk("restart_first_load", 0, ldv[0][0], 200);
    chk("restart_tokens", 0, toks[0], 16);
    chk("restart_done", 0, dones[0], 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/partition_scheduler.md
Name: partition_scheduler

Overview:
- Sequences the partition read-address generator across a full ARRAY_WIDTH x ARRAY_HEIGHT feature map, one partition (window) at a time, in raster order with a fixed stride.
- For each partition it computes the base address, loads it into the generator, holds it in run until the generator reports done, then hands a tile-complete token to the downstream accumulator.
- It sits between the layer controller (start/done) and the address generator and window datapath.

Parameters:
- ARRAY_WIDTH, 28, feature-map width in words
- ARRAY_HEIGHT, 28, feature-map height in words
- PARTITION_WIDTH, 5, window width
- PARTITION_HEIGHT, 5, window height
- STRIDE, 1, window step in both x and y; must be >=1
- ADDRESS_WIDTH, 16, address bus width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to process one full map; sampled only in IDLE
- base_addr  in  ADDRESS_WIDTH  address of map element (0,0); captured on accepted start
- agen_address  out  ADDRESS_WIDTH  partition base driven to the generator's address_in
- agen_run  out  1  generator run; low loads agen_address, high walks the window
- agen_done  in  1  generator last-element flag, combinational from the generator
- tile_valid  out  1  partition finished, token waiting for the consumer
- tile_ready  in  1  consumer accepts the token
- tile_x  out  ADDRESS_WIDTH  x index of the finished partition, valid with tile_valid
- tile_y  out  ADDRESS_WIDTH  y index of the finished partition, valid with tile_valid
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final token is accepted

Behaviour:
- Constants:
  - TILES_X = (ARRAY_WIDTH-PARTITION_WIDTH)/STRIDE+1
  - TILES_Y = (ARRAY_HEIGHT-PARTITION_HEIGHT)/STRIDE+1
  - Integer division.
- Reset (async, rst_n low): state IDLE; all counters 0; agen_address=0; agen_run, tile_valid, busy and done all 0.
- States: IDLE, LOAD, RUN, TILE, DONE.
- IDLE:
  - On start=1, capture base_addr into row_base and cur_base, clear tx and ty, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (exactly 1 cycle):
  - agen_run=0 and agen_address=cur_base, so the generator latches the base.
  - Next state is RUN.
- RUN:
  - agen_run=1.
  - When agen_done=1, go to TILE; agen_run drops the following cycle.
  - agen_run is high for exactly PARTITION_WIDTH*PARTITION_HEIGHT cycles per partition.
- TILE:
  - agen_run=0, tile_valid=1, with tile_x=tx and tile_y=ty held stable.
  - On tile_valid&&tile_ready, advance the indices:
    - If tx<TILES_X-1: tx++, cur_base += STRIDE.
    - Else if ty<TILES_Y-1: tx=0, ty++, row_base += STRIDE*ARRAY_WIDTH, cur_base = new row_base.
    - Else go to DONE.
  - Non-final acceptance goes to LOAD.
  - tile_valid must not drop without acceptance.
- DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- busy is 1 in LOAD, RUN and TILE.
- Arithmetic:
  - All address arithmetic is modulo 2^ADDRESS_WIDTH.
  - STRIDE*ARRAY_WIDTH is an elaboration-time constant; no runtime multiply.
- Per-partition overhead: 1 LOAD cycle plus at least 1 TILE cycle, giving a minimum period of PW*PH+2 cycles.
- Boundary conditions:
  - start while busy is ignored.
  - agen_done outside RUN is ignored.
  - A map with PARTITION equal to ARRAY produces exactly 1 tile.
  - Leftover columns or rows smaller than the stride remainder are not visited.
  - tile_ready held high gives back-to-back partitions with no extra cycles.
  - rst_n low mid-RUN immediately forces agen_run=0 and IDLE, with no done pulse.

Decomposition:
- Package partition_sched_pkg holds:
  - the state enum type
  - the TILES_X/TILES_Y computation functions
  - the row-step constant function
- One sub-module, tile_index_counter: the nested tx/ty counter with row_base/cur_base advance. Inputs are clear and advance; outputs are tx, ty, cur_base and last.
- The FSM stays in the top.

Test Plan:
- ARRAY 6x6, PARTITION 3x3, STRIDE 1, base_addr=100, tile_ready tied 1 -> 16 tokens with (x,y) (0,0)..(3,3). agen_address per LOAD is 100,101,102,103,106,...,121. Each RUN is 9 cycles; done pulses once; total 16*11+1 cycles from start to done.
- Same map with STRIDE 3, base 0 -> 4 tokens, bases 0,3,18,21.
- PARTITION == ARRAY 4x4 -> exactly one LOAD, 16 RUN cycles, 1 token, done.
- tile_ready low for 5 cycles on token (2,1) -> tile_valid, tile_x=2 and tile_y=1 held stable, agen_run=0 throughout, next LOAD only after acceptance.
- start pulsed during RUN -> ignored, token count unchanged. rst_n asserted during RUN of tile 5 -> agen_run=0 and busy=0 asynchronously; a fresh start restarts from tile (0,0).
- base_addr=16'hFFFE, 2x2 tiles of a 3x3 map with 2x2 partitions -> bases FFFE, FFFF, 0001, 0002 (wrap modulo 2^16).
